demux_route_ctrl: RTL
=====================

Name: demux_route_ctrl

Overview:
- Upstream feeder for the 32-bit two-way data demux: buffers incoming data words and drives the demux `sel` and `din` from a queued head entry.
- Steers each word to path 0 (normal) or path 1 (secure) according to its address, and drops non-privileged accesses to the secure window.
- Provides per-path valid/ready handshakes so each demux output can be consumed independently.

Parameters:
- DATA_SIZE, 32, width of data word; matches demux data_size
- ADDR_SIZE, 32, width of request address
- FIFO_DEPTH, 4, queue entries; power of two, at least 2
- SEC_BASE, 32'h0000_F000, lowest address of secure window (inclusive)
- SEC_LIMIT, 32'h0000_FFFF, highest address of secure window (inclusive)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  request present
- in_ready  output  1  block can accept a request
- in_addr  input  ADDR_SIZE  request address
- in_data  input  DATA_SIZE  request data
- in_priv  input  1  requester is privileged (secure mode)
- sel  output  1  to demux sel; 1 = secure path
- dout  output  DATA_SIZE  to demux din
- out_valid_0  output  1  head entry valid for path 0
- out_valid_1  output  1  head entry valid for path 1
- out_ready_0  input  1  path-0 consumer accepts
- out_ready_1  input  1  path-1 consumer accepts
- viol  output  1  one-cycle pulse on a dropped access
- fifo_count  output  log2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Clock and reset:
  - Single clock `clk`; reset `rst_n` is synchronous and active-low.
  - Reset is sampled only on the rising edge of `clk`.
- Reset values:
  - All state is cleared: `sel`=0, `dout`=0, `out_valid_0`=0, `out_valid_1`=0, `viol`=0, `fifo_count`=0.
  - Read and write pointers are 0; the error counter (if present) is 0.
  - `in_ready`=1 while `rst_n` is high after reset.
  - A reset asserted mid-operation discards all queued entries with no output pulses.
- Classification (combinational on input):
  - Secure hit = (`in_addr` >= SEC_BASE) && (`in_addr` <= SEC_LIMIT), unsigned compare.
  - Route bit = secure hit.
  - Violation = secure hit && !`in_priv`.
- Accept:
  - Handshake completes when `in_valid` && `in_ready`.
  - `in_ready` = !full; no push while full, even if a pop occurs in the same cycle.
- Push:
  - A non-violating accept writes {route, `in_data`} at the write pointer; the write pointer increments modulo FIFO_DEPTH.
  - A violating accept is consumed (handshake completes) but is not written.
  - `viol` is registered and goes high for exactly the next cycle.
- Head / output:
  - `sel` = route bit of the head entry and `dout` = data of the head entry, both driven from FIFO storage.
  - When the FIFO is empty: `sel`=0, `dout`=0 (demux outputs are zero).
  - `out_valid_0` = !empty && !head.route.
  - `out_valid_1` = !empty && head.route.
- Pop:
  - Pop occurs when (`out_valid_0` && `out_ready_0`) || (`out_valid_1` && `out_ready_1`).
  - The ready of the non-selected path is ignored.
  - The read pointer increments modulo FIFO_DEPTH.
- Latency:
  - A word accepted at edge N is presented at head after edge N when the FIFO is empty (1 cycle).
  - Throughput is 1 word/cycle.
- Simultaneous push and pop when not full: count unchanged and both pointers advance.
- Empty:
  - No pop occurs regardless of readies.
  - Pointer wrap is seamless (depth-4: write pointer 3 → 0).
- Ordering: strict FIFO order across both paths. A blocked head stalls subsequent words destined for the other path; this is intended and preserves program order.
- `fifo_count`: registered occupancy, range 0..FIFO_DEPTH.

Optional Feature:
- Macro: DEMUX_ROUTE_ERR_CNT_EN.
- When defined:
  - Adds output port `err_count` (16 bits).
  - A 16-bit counter increments on each dropped violation and saturates at 16'hFFFF.
  - Adds input `err_clr`; when high, the counter is cleared on the next edge.
  - `err_clr` takes priority over a simultaneous increment.
  - Counter reset value is 0.
- When undefined:
  - No counter, no `err_count` or `err_clr` ports.
  - `viol` pulse behaviour is unchanged.

Test Plan:
- Reset then idle → `in_ready`=1, `fifo_count`=0, `out_valid_0`=0, `out_valid_1`=0, `sel`=0, `dout`=0.
- Push addr 0x0000_1000, data 0xA5A5_0001, `in_priv`=0 → next cycle `out_valid_0`=1, `sel`=0, `dout`=0xA5A5_0001; with `out_ready_0`=1 → `fifo_count` returns to 0.
- Push addr 0x0000_F000, `in_priv`=1, data 0x5 → `out_valid_1`=1, `sel`=1; hold `out_ready_1`=0 and assert `out_ready_0`=1 → entry retained, no pop.
- Push addr 0x0000_FFFF, `in_priv`=0 → handshake completes, `viol`=1 for one cycle, `fifo_count` unchanged; with the macro defined, `err_count` goes 0→1.
- Hold both readies low and push 5 words → `in_ready`=0 after the 4th, `fifo_count`=4; release readies → words 1-4 emerge in order, the 5th is accepted once `in_ready` rises, and pointers wrap correctly.
- Assert `rst_n`=0 for one cycle with 3 queued entries → next cycle `fifo_count`=0, both valids 0, and no `viol` pulse.

Source files
------------

// File: rtl/demux_route_ctrl_if.sv
// Handshake/bus bundle between the route controller and its environment.
// The slave modport is the controller side; master is the feeder/consumer side.
interface demux_route_ctrl_if #(
   parameter int DATA_SIZE  = 32,
   parameter int ADDR_SIZE  = 32,
   parameter int FIFO_DEPTH = 4
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic                 in_valid;
   logic                 in_ready;
   logic [ADDR_SIZE-1:0] in_addr;
   logic [DATA_SIZE-1:0] in_data;
   logic                 in_priv;
   logic                 sel;
   logic [DATA_SIZE-1:0] dout;
   logic                 out_valid_0;
   logic                 out_valid_1;
   logic                 out_ready_0;
   logic                 out_ready_1;
   logic                 viol;
   logic [CNT_W-1:0]     fifo_count;

   modport master (
      output in_valid, in_addr, in_data, in_priv, out_ready_0, out_ready_1,
      input  in_ready, sel, dout, out_valid_0, out_valid_1, viol, fifo_count
   );

   modport slave (
      input  in_valid, in_addr, in_data, in_priv, out_ready_0, out_ready_1,
      output in_ready, sel, dout, out_valid_0, out_valid_1, viol, fifo_count
   );
endinterface

// File: rtl/demux_route_ctrl.sv
// Queued feeder for the two-way data demux: routes words to the normal or secure path by address.
// Optional macro DEMUX_ROUTE_ERR_CNT_EN adds a saturating dropped-access counter (err_count/err_clr).
module demux_route_ctrl #(
   parameter int                  DATA_SIZE  = 32,
   parameter int                  ADDR_SIZE  = 32,
   parameter int                  FIFO_DEPTH = 4,
   parameter logic [ADDR_SIZE-1:0] SEC_BASE  = 32'h0000_F000,
   parameter logic [ADDR_SIZE-1:0] SEC_LIMIT = 32'h0000_FFFF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   demux_route_ctrl_if.slave    bus
`ifdef DEMUX_ROUTE_ERR_CNT_EN
   ,
   input  logic                 err_clr,
   output logic [15:0]          err_count
`endif
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   typedef struct packed {
      logic                 route;
      logic [DATA_SIZE-1:0] data;
   } entry_t;

   function automatic logic sec_hit(input logic [ADDR_SIZE-1:0] addr);
      return (addr >= SEC_BASE) && (addr <= SEC_LIMIT);
   endfunction

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
      return ptr + PTR_W'(1);
   endfunction

   entry_t           mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_p1;
   logic [PTR_W-1:0] rd_ptr_p1;
   logic [CNT_W-1:0] count_p1;
   logic             viol_p1;

   logic             hit_p0;
   logic             is_viol_p0;
   logic             full;
   logic             empty;
   logic             accept;
   logic             push;
   logic             pop;
   logic             ov0;
   logic             ov1;
   entry_t           head;

   // ---- stage p0: classify request, decide accept/push/pop ----
   always_comb begin
      hit_p0     = sec_hit(bus.in_addr);
      is_viol_p0 = hit_p0 && !bus.in_priv;
      full       = (count_p1 == CNT_W'(FIFO_DEPTH));
      empty      = (count_p1 == '0);
      accept     = bus.in_valid && !full;
      push       = accept && !is_viol_p0;
      head       = mem[rd_ptr_p1];
      ov0        = !empty && !head.route;
      ov1        = !empty && head.route;
      pop        = (ov0 && bus.out_ready_0) || (ov1 && bus.out_ready_1);
   end

   assign bus.in_ready    = !full;
   assign bus.out_valid_0 = ov0;
   assign bus.out_valid_1 = ov1;
   // The head is gated so the demux sees all-zero inputs while the queue is empty.
   assign bus.sel         = empty ? 1'b0 : head.route;
   assign bus.dout        = empty ? '0 : head.data;
   assign bus.viol        = viol_p1;
   assign bus.fifo_count  = count_p1;

   // ---- stage p1: storage, pointers, occupancy, violation pulse ----
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_p1] <= '{route: hit_p0, data: bus.in_data};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_p1 <= '0;
         rd_ptr_p1 <= '0;
         count_p1  <= '0;
         viol_p1   <= 1'b0;
      end else begin
         if (push) wr_ptr_p1 <= ptr_inc(wr_ptr_p1);
         if (pop)  rd_ptr_p1 <= ptr_inc(rd_ptr_p1);
         case ({push, pop})
            2'b10:   count_p1 <= count_p1 + CNT_W'(1);
            2'b01:   count_p1 <= count_p1 - CNT_W'(1);
            default: count_p1 <= count_p1;
         endcase
         viol_p1 <= accept && is_viol_p0;
      end
   end

`ifdef DEMUX_ROUTE_ERR_CNT_EN
   logic [15:0] err_p1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_p1 <= '0;
      end else if (err_clr) begin
         err_p1 <= '0;
      end else if (accept && is_viol_p0 && (err_p1 != 16'hFFFF)) begin
         err_p1 <= err_p1 + 16'd1;
      end
   end

   assign err_count = err_p1;
`endif

endmodule
